// File: rtl/float_pkg.sv
// Shared definitions for the binary32 stream multiplier: FSM states, format constants
// and the operand classifier used to pick the special-case path.
package float_pkg;

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B,
        MUL_0, MUL_1, NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam int          EXP_BIAS = 127;
    localparam int          EMIN     = -126;
    localparam int          EMAX     = 127;
    localparam logic [7:0]  INF_EXP  = 8'hFF;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == INF_EXP) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == INF_EXP) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'd0) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_denorm(input logic [31:0] x);
        return (x[30:23] == 8'd0) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/float_multiplier_stream.sv
// IEEE-754 binary32 multiplier between two stb/ack operand streams and one result
// stream; multi-cycle FSM, round-to-nearest-even, denormals handled in and out.
module float_multiplier_stream
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    localparam logic signed [9:0] BIAS10 = 10'(EXP_BIAS);
    localparam logic signed [9:0] EMIN10 = 10'(EMIN);
    localparam logic signed [9:0] EMAX10 = 10'(EMAX);

    state_t             state_reg;
    logic [31:0]        a_reg, b_reg;
    logic [23:0]        a_m_reg, b_m_reg, z_m_reg;
    logic signed [9:0]  a_e_reg, b_e_reg, z_e_reg;
    logic               a_s_reg, b_s_reg;
    logic               guard_reg, round_reg, sticky_reg;
    logic [47:0]        product_reg;
    logic signed [9:0]  pack_e;

    assign pack_e = z_e_reg + BIAS10;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= 32'd0;
            a_reg        <= 32'd0;
            b_reg        <= 32'd0;
            a_m_reg      <= 24'd0;
            b_m_reg      <= 24'd0;
            z_m_reg      <= 24'd0;
            a_e_reg      <= 10'sd0;
            b_e_reg      <= 10'sd0;
            z_e_reg      <= 10'sd0;
            a_s_reg      <= 1'b0;
            b_s_reg      <= 1'b0;
            guard_reg    <= 1'b0;
            round_reg    <= 1'b0;
            sticky_reg   <= 1'b0;
            product_reg  <= 48'd0;
        end else begin
            case (state_reg)
                GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a_reg       <= input_a;
                        input_a_ack <= 1'b0;
                        state_reg   <= GET_B;
                    end
                end
                GET_B: begin
                    input_b_ack <= 1'b1;
                    if (input_b_ack && input_b_stb) begin
                        b_reg       <= input_b;
                        input_b_ack <= 1'b0;
                        state_reg   <= UNPACK;
                    end
                end
                UNPACK: begin
                    a_m_reg   <= {1'b0, a_reg[22:0]};
                    b_m_reg   <= {1'b0, b_reg[22:0]};
                    a_e_reg   <= $signed({2'b00, a_reg[30:23]}) - BIAS10;
                    b_e_reg   <= $signed({2'b00, b_reg[30:23]}) - BIAS10;
                    a_s_reg   <= a_reg[31];
                    b_s_reg   <= b_reg[31];
                    state_reg <= SPECIAL;
                end
                SPECIAL: begin
                    if (is_nan(a_reg) || is_nan(b_reg) ||
                        (is_inf(a_reg) && is_zero(b_reg)) ||
                        (is_inf(b_reg) && is_zero(a_reg))) begin
                        output_z     <= QNAN;
                        output_z_stb <= 1'b1;
                        state_reg    <= PUT_Z;
                    end else if (is_inf(a_reg) || is_inf(b_reg)) begin
                        output_z     <= {a_s_reg ^ b_s_reg, INF_EXP, 23'd0};
                        output_z_stb <= 1'b1;
                        state_reg    <= PUT_Z;
                    end else if (is_zero(a_reg) || is_zero(b_reg)) begin
                        output_z     <= {a_s_reg ^ b_s_reg, 31'd0};
                        output_z_stb <= 1'b1;
                        state_reg    <= PUT_Z;
                    end else begin
                        // Denormals share the minimum exponent and lack the hidden one.
                        if (is_denorm(a_reg)) a_e_reg <= EMIN10;
                        else                  a_m_reg[23] <= 1'b1;
                        if (is_denorm(b_reg)) b_e_reg <= EMIN10;
                        else                  b_m_reg[23] <= 1'b1;
                        state_reg <= NORM_A;
                    end
                end
                NORM_A: begin
                    if (a_m_reg[23]) begin
                        state_reg <= NORM_B;
                    end else begin
                        a_m_reg <= {a_m_reg[22:0], 1'b0};
                        a_e_reg <= a_e_reg - 10'sd1;
                    end
                end
                NORM_B: begin
                    if (b_m_reg[23]) begin
                        state_reg <= MUL_0;
                    end else begin
                        b_m_reg <= {b_m_reg[22:0], 1'b0};
                        b_e_reg <= b_e_reg - 10'sd1;
                    end
                end
                MUL_0: begin
                    z_e_reg     <= a_e_reg + b_e_reg + 10'sd1;
                    product_reg <= 48'(a_m_reg) * 48'(b_m_reg);
                    state_reg   <= MUL_1;
                end
                MUL_1: begin
                    z_m_reg    <= product_reg[47:24];
                    guard_reg  <= product_reg[23];
                    round_reg  <= product_reg[22];
                    sticky_reg <= |product_reg[21:0];
                    state_reg  <= NORM_1;
                end
                NORM_1: begin
                    if (z_m_reg[23]) begin
                        state_reg <= NORM_2;
                    end else begin
                        z_m_reg   <= {z_m_reg[22:0], guard_reg};
                        guard_reg <= round_reg;
                        round_reg <= 1'b0;
                        z_e_reg   <= z_e_reg - 10'sd1;
                    end
                end
                NORM_2: begin
                    // Denormalise towards EMIN, folding shifted-out bits into sticky.
                    if (z_e_reg < EMIN10) begin
                        z_e_reg    <= z_e_reg + 10'sd1;
                        z_m_reg    <= {1'b0, z_m_reg[23:1]};
                        guard_reg  <= z_m_reg[0];
                        round_reg  <= guard_reg;
                        sticky_reg <= sticky_reg | round_reg;
                    end else begin
                        state_reg <= ROUND;
                    end
                end
                ROUND: begin
                    if (guard_reg && (round_reg || sticky_reg || z_m_reg[0])) begin
                        z_m_reg <= z_m_reg + 24'd1;
                        if (z_m_reg == 24'hFFFFFF) z_e_reg <= z_e_reg + 10'sd1;
                    end
                    state_reg <= PACK;
                end
                PACK: begin
                    if (z_e_reg > EMAX10)
                        output_z <= {a_s_reg ^ b_s_reg, INF_EXP, 23'd0};
                    else if (z_e_reg == EMIN10 && !z_m_reg[23])
                        output_z <= {a_s_reg ^ b_s_reg, 8'd0, z_m_reg[22:0]};
                    else
                        output_z <= {a_s_reg ^ b_s_reg, pack_e[7:0], z_m_reg[22:0]};
                    output_z_stb <= 1'b1;
                    state_reg    <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state_reg    <= GET_A;
                    end
                end
                default: state_reg <= GET_A;
            endcase
        end
    end

endmodule
